mmu_operand_feeder: RTL and testbench
=====================================

// Module: mmu_operand_feeder
// PURPOSE
//  - Operand store and skew sequencer between host load path and 2x2 systolic MMU.
//  - Captures 8 elements (A row-major @0-3, B row-major @4-7) on load strobes from the control unit.
//  - During feed, emits diagonally skewed A rows / B columns per feed cycle, plus clear and valid pulses.
// PARAMETERS
//  DATA_W   8   element width, unsigned
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset, asynchronous, active-low
//  load_en    in   1       write load_data to element load_addr this cycle
//  load_addr  in   3       0:a00 1:a01 2:a10 3:a11 4:b00 5:b01 6:b10 7:b11
//  load_data  in   DATA_W  element value
//  feed_en    in   1       feed phase active (control unit feeding_en)
//  feed_cycle in   3       feed cycle index 0..5 (control unit mmu_cycles)
//  a_row0     out  DATA_W  A operand into PE row 0
//  a_row1     out  DATA_W  A operand into PE row 1
//  b_col0     out  DATA_W  B operand into PE column 0
//  b_col1     out  DATA_W  B operand into PE column 1
//  feed_valid out  1       operands on a_/b_ outputs are meaningful
//  mmu_clear  out  1       one-cycle accumulator clear, aligned with first operands
//  mats_ready out  1       all 8 elements of the feed bank written since last feed
//  load_err   out  1       sticky: load dropped (written during FEED)
// BEHAVIOUR
//  - Reset: all outputs 0, storage 0, written-mask 0, state IDLE.
//  - Storage: 8 x DATA_W regs; write at posedge when load_en; visible to a feed sampled >= 1 edge later.
//  - Written-mask: bit set per load_addr; mats_ready = &mask; mask clears at feed start.
//  - FSM: IDLE -> FEED when feed_en && feed_cycle==0; FEED -> DRAIN when feed_en falls or feed_cycle==5;
//    DRAIN -> IDLE after 1 cycle (outputs forced 0). feed_en with feed_cycle!=0 in IDLE: ignored.
//  - All operand outputs registered: schedule row k driven 1 cycle after edge sampling feed_cycle==k.
//    k=0: a_row0=a00 a_row1=0   b_col0=b00 b_col1=0   mmu_clear=1
//    k=1: a_row0=a01 a_row1=a10 b_col0=b10 b_col1=b01
//    k=2: a_row0=0   a_row1=a11 b_col0=0   b_col1=b11
//    k=3..5: all operands 0 (pipeline flush); feed_valid=1 for k=0..2 only.
//  - Outside FEED: operands, feed_valid, mmu_clear = 0.
//  - Loads during FEED/DRAIN dropped, load_err<=1; load_err clears only on reset or next feed start.
//  - Feed with mats_ready=0: proceeds with stale contents, no error.
//  - Reset mid-feed: immediate zero outputs, storage lost, IDLE.
//  - Same load_addr written twice: last write wins; mask unaffected.
// CONFIGURATION
//  MMU_FEEDER_DOUBLE_BUF_EN defined: two banks (active/shadow). Loads always write shadow and are
//   never dropped (load_err tied 0). Shadow mask full while not FEED/DRAIN: swap banks same edge,
//   mask clears; full during FEED/DRAIN: swap on DRAIN->IDLE edge. Feed reads active bank only;
//   mats_ready = active bank complete and not yet fed.
//  Undefined: single bank, behaviour as above.
// STRUCTURE
//  - mmu_pkg: DATA_W default, element address localparams (ADDR_A00..ADDR_B11),
//    FEED_LAST_CYCLE=3'd5, feeder state encoding.
//  - Sub-module mmu_operand_bank: 8-entry reg file, one write port, 8 parallel read outputs, write mask;
//    instantiated once (twice with double-buffer).
// TESTING
//  1. Load A=[1,2,3,4] B=[5,6,7,8], feed 0..5 -> (a0,a1,b0,b1)=(1,0,5,0)+clear,(2,3,7,6),(0,4,0,8),then zeros;
//     feed_valid 3 cycles; mats_ready 1 before, 0 after.
//  2. Load 7 elements only -> mats_ready=0; 8th -> mats_ready=1 next cycle.
//  3. load_en during feed cycle 2 (single bank) -> storage unchanged, load_err=1 until next feed start.
//  4. rst_n low at feed cycle 1 -> outputs 0 immediately; after release, feed gives all-zero operands.
//  5. feed_en drops at cycle 1 -> DRAIN, outputs 0 next cycle, IDLE after one more.
//  6. DOUBLE_BUF: load B-set [9..16] during feed of set 1 -> set 1 feed intact, swap at DRAIN->IDLE,
//     next feed emits a00=9, b00=13.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared constants and feeder state encoding for the 2x2 MMU operand path.
package mmu_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int N_ELEM     = 8;

   // Element addresses: A row-major at 0-3, B row-major at 4-7.
   localparam logic [2:0] ADDR_A00 = 3'd0;
   localparam logic [2:0] ADDR_A01 = 3'd1;
   localparam logic [2:0] ADDR_A10 = 3'd2;
   localparam logic [2:0] ADDR_A11 = 3'd3;
   localparam logic [2:0] ADDR_B00 = 3'd4;
   localparam logic [2:0] ADDR_B01 = 3'd5;
   localparam logic [2:0] ADDR_B10 = 3'd6;
   localparam logic [2:0] ADDR_B11 = 3'd7;

   localparam logic [2:0] FEED_LAST_CYCLE = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } feed_state_e;

   // One-hot mask bit for an element address.
   function automatic logic [N_ELEM-1:0] elem_bit(input logic [2:0] addr);
      return N_ELEM'(1) << addr;
   endfunction

endpackage

// File: rtl/mmu_operand_bank.sv
// mmu_operand_bank: 8-entry operand register file with one write port, all entries
// readable in parallel, and a per-entry written mask.
module mmu_operand_bank
   import mmu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en_i,
   input  logic [2:0]                     wr_addr_i,
   input  logic [DATA_W-1:0]              wr_data_i,
   input  logic                           mask_clr_i,
   output logic [N_ELEM-1:0][DATA_W-1:0]  rd_data_o,
   output logic [N_ELEM-1:0]              mask_o
);

   logic [N_ELEM-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [N_ELEM-1:0]             mask_q, mask_d;

   // A write landing on the same edge as a mask clear still counts for the next feed.
   always_comb begin
      mem_d  = mem_q;
      mask_d = mask_clr_i ? '0 : mask_q;
      if (wr_en_i) begin
         mem_d[wr_addr_i] = wr_data_i;
         mask_d           = mask_d | elem_bit(wr_addr_i);
      end
   end

   // Storage and mask registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         mask_q <= '0;
      end else begin
         mem_q  <= mem_d;
         mask_q <= mask_d;
      end
   end

   assign rd_data_o = mem_q;
   assign mask_o    = mask_q;

endmodule

// File: rtl/mmu_operand_feeder.sv
// mmu_operand_feeder: operand store and diagonal skew sequencer for a 2x2 systolic MMU.
// Optional build macro MMU_FEEDER_DOUBLE_BUF_EN: active/shadow banks, loads never dropped.
//
// state    | meaning
// ST_IDLE  | waiting for feed_en with feed_cycle 0; loads accepted
// ST_FEED  | emitting skewed operands, one schedule row per sampled feed cycle
// ST_DRAIN | one cycle with operands forced to 0, then back to idle
module mmu_operand_feeder
   import mmu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en_i,
   input  logic [2:0]        load_addr_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              feed_en_i,
   input  logic [2:0]        feed_cycle_i,
   output logic [DATA_W-1:0] a_row0_o,
   output logic [DATA_W-1:0] a_row1_o,
   output logic [DATA_W-1:0] b_col0_o,
   output logic [DATA_W-1:0] b_col1_o,
   output logic              feed_valid_o,
   output logic              mmu_clear_o,
   output logic              mats_ready_o,
   output logic              load_err_o
);

   feed_state_e state_q, state_d;
   logic        feed_start, feed_live;
   logic [N_ELEM-1:0][DATA_W-1:0] elem;

   logic [DATA_W-1:0] a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
   logic              valid_q, valid_d, clear_q, clear_d;

   assign feed_start = (state_q == ST_IDLE) && feed_en_i && (feed_cycle_i == 3'd0);
   assign feed_live  = feed_start || ((state_q == ST_FEED) && feed_en_i);

`ifdef MMU_FEEDER_DOUBLE_BUF_EN
   logic                                      act_q, act_d, swap;
   logic [1:0][N_ELEM-1:0][DATA_W-1:0]        bank_data;
   logic [1:0][N_ELEM-1:0]                    bank_mask;
   logic [1:0]                                bank_we, bank_clr;
   logic [N_ELEM-1:0]                         sh_mask_next;

   // Shadow completion includes this edge's write; held off while a feed is running.
   assign sh_mask_next = bank_mask[~act_q] | (load_en_i ? elem_bit(load_addr_i) : '0);
   assign swap         = (&sh_mask_next) && (state_q != ST_FEED);
   assign act_d        = swap ? ~act_q : act_q;

   assign bank_we[0]  = load_en_i && act_q;
   assign bank_we[1]  = load_en_i && !act_q;
   assign bank_clr[0] = !act_q && (feed_start || swap);
   assign bank_clr[1] = act_q && (feed_start || swap);

   for (genvar g = 0; g < 2; g++) begin : g_bank
      mmu_operand_bank #(.DATA_W(DATA_W)) u_bank (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_en_i    (bank_we[g]),
         .wr_addr_i  (load_addr_i),
         .wr_data_i  (load_data_i),
         .mask_clr_i (bank_clr[g]),
         .rd_data_o  (bank_data[g]),
         .mask_o     (bank_mask[g])
      );
   end

   // Active bank selector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) act_q <= 1'b0;
      else        act_q <= act_d;
   end

   assign elem         = bank_data[act_q];
   assign mats_ready_o = &bank_mask[act_q];
   assign load_err_o   = 1'b0;
`else
   logic              err_q, err_d;
   logic [N_ELEM-1:0] mask;

   mmu_operand_bank #(.DATA_W(DATA_W)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (load_en_i && (state_q == ST_IDLE)),
      .wr_addr_i  (load_addr_i),
      .wr_data_i  (load_data_i),
      .mask_clr_i (feed_start),
      .rd_data_o  (elem),
      .mask_o     (mask)
   );

   assign err_d = feed_start ? 1'b0 : (err_q || (load_en_i && (state_q != ST_IDLE)));

   // Sticky dropped-load flag, cleared when the next feed starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign mats_ready_o = &mask;
   assign load_err_o   = err_q;
`endif

   // Sequencer next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (feed_start) state_d = ST_FEED;
         ST_FEED:  if (!feed_en_i || (feed_cycle_i == FEED_LAST_CYCLE)) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Skew schedule: row k is registered on the edge that samples feed_cycle k.
   always_comb begin
      a0_d    = '0;
      a1_d    = '0;
      b0_d    = '0;
      b1_d    = '0;
      valid_d = 1'b0;
      clear_d = 1'b0;
      if (feed_live) begin
         case (feed_cycle_i)
            3'd0: begin
               a0_d    = elem[ADDR_A00];
               b0_d    = elem[ADDR_B00];
               valid_d = 1'b1;
               clear_d = 1'b1;
            end
            3'd1: begin
               a0_d    = elem[ADDR_A01];
               a1_d    = elem[ADDR_A10];
               b0_d    = elem[ADDR_B10];
               b1_d    = elem[ADDR_B01];
               valid_d = 1'b1;
            end
            3'd2: begin
               a1_d    = elem[ADDR_A11];
               b1_d    = elem[ADDR_B11];
               valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a0_q    <= '0;
         a1_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         valid_q <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         valid_q <= valid_d;
         clear_q <= clear_d;
      end
   end

   assign a_row0_o     = a0_q;
   assign a_row1_o     = a1_q;
   assign b_col0_o     = b0_q;
   assign b_col1_o     = b1_q;
   assign feed_valid_o = valid_q;
   assign mmu_clear_o  = clear_q;

endmodule

// File: tb/tb_mmu_operand_feeder.sv
// tb_mmu_operand_feeder: directed scenarios plus randomized load/feed traffic,
// compared against a behavioural operand-store model.
module tb_mmu_operand_feeder;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_en = 1'b0;
   logic [2:0]    load_addr = '0;
   logic [DW-1:0] load_data = '0;
   logic          feed_en = 1'b0;
   logic [2:0]    feed_cycle = '0;
   logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
   logic          feed_valid, mmu_clear, mats_ready, load_err;

   always #5 clk = ~clk;

   mmu_operand_feeder #(.DATA_W(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_en_i    (load_en),
      .load_addr_i  (load_addr),
      .load_data_i  (load_data),
      .feed_en_i    (feed_en),
      .feed_cycle_i (feed_cycle),
      .a_row0_o     (a_row0),
      .a_row1_o     (a_row1),
      .b_col0_o     (b_col0),
      .b_col1_o     (b_col1),
      .feed_valid_o (feed_valid),
      .mmu_clear_o  (mmu_clear),
      .mats_ready_o (mats_ready),
      .load_err_o   (load_err)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Element order 0..7 = a00 a01 a10 a11 b00 b01 b10 b11; -1 means drive zero.
   int A0_SRC [3] = '{0, 1, -1};
   int A1_SRC [3] = '{-1, 2, 3};
   int B0_SRC [3] = '{4, 6, -1};
   int B1_SRC [3] = '{-1, 5, 7};

   logic [DW-1:0] m_mem [2][8];
   bit            m_wr  [2][8];
   int            m_act;
   int            m_phase;   // 0 waiting, 1 feeding, 2 draining
   logic [DW-1:0] e_a0, e_a1, e_b0, e_b1;
   bit            e_valid, e_clear, e_err;

   function automatic bit all_written(input int b);
      for (int i = 0; i < 8; i++) if (!m_wr[b][i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [DW-1:0] pick(input int idx);
      return (idx < 0) ? '0 : m_mem[m_act][idx];
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 8; i++) begin
            m_mem[b][i] = '0;
            m_wr[b][i]  = 1'b0;
         end
      m_act = 0; m_phase = 0;
      e_a0 = '0; e_a1 = '0; e_b0 = '0; e_b1 = '0;
      e_valid = 0; e_clear = 0; e_err = 0;
   endtask

   task automatic model_edge(input bit ld, input logic [2:0] addr, input logic [DW-1:0] data,
                             input bit fen, input logic [2:0] fc);
      bit start, live;
      int old_phase, k, sh;
      old_phase = m_phase;
      start = (m_phase == 0) && fen && (fc == 3'd0);
      live  = start || (m_phase == 1 && fen);
      k = int'(fc);
      e_a0 = '0; e_a1 = '0; e_b0 = '0; e_b1 = '0; e_valid = 0; e_clear = 0;
      if (live && k <= 2) begin
         e_a0 = pick(A0_SRC[k]); e_a1 = pick(A1_SRC[k]);
         e_b0 = pick(B0_SRC[k]); e_b1 = pick(B1_SRC[k]);
         e_valid = 1; e_clear = (k == 0);
      end
      case (m_phase)
         0: if (start) m_phase = 1;
         1: if (!fen || k == 5) m_phase = 2;
         default: m_phase = 0;
      endcase
      if (start) for (int i = 0; i < 8; i++) m_wr[m_act][i] = 1'b0;
`ifdef MMU_FEEDER_DOUBLE_BUF_EN
      sh = 1 - m_act;
      if (ld) begin m_mem[sh][addr] = data; m_wr[sh][addr] = 1'b1; end
      if (all_written(sh) && old_phase != 1) begin
         m_act = sh;
         for (int i = 0; i < 8; i++) m_wr[1 - m_act][i] = 1'b0;
      end
      e_err = 0;
`else
      sh = 0;
      if (start) e_err = 0;
      if (ld) begin
         if (old_phase == 0) begin m_mem[0][addr] = data; m_wr[0][addr] = 1'b1; end
         else e_err = 1;
      end
`endif
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".a_row0"}, a_row0, e_a0);
      chk({tag, ".a_row1"}, a_row1, e_a1);
      chk({tag, ".b_col0"}, b_col0, e_b0);
      chk({tag, ".b_col1"}, b_col1, e_b1);
      chk({tag, ".feed_valid"}, feed_valid, e_valid);
      chk({tag, ".mmu_clear"}, mmu_clear, e_clear);
      chk({tag, ".mats_ready"}, mats_ready, all_written(m_act));
      chk({tag, ".load_err"}, load_err, e_err);
   endtask

   // One clock: drive inputs, advance DUT and model on the same edge, compare 1ns later.
   task automatic step(input string tag, input bit ld, input logic [2:0] addr,
                       input logic [DW-1:0] data, input bit fen, input logic [2:0] fc);
      load_en = ld; load_addr = addr; load_data = data; feed_en = fen; feed_cycle = fc;
      @(posedge clk);
      model_edge(ld, addr, data, fen, fc);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 3'd0, '0, 0, 3'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [DW-1:0] t2_a00;

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk); rst_n = 1'b1;
      #1;
      idle("post_reset");

      // Test 1: A=[1,2,3,4] B=[5,6,7,8], full feed.
      for (int i = 0; i < 8; i++) step("t1_load", 1, 3'(i), DW'(i + 1), 0, 3'd0);
      chk("t1_ready_before", mats_ready, 1);
      step("t1_k0", 0, 3'd0, '0, 1, 3'd0);
      chk("t1_k0_a0", a_row0, 1); chk("t1_k0_b0", b_col0, 5); chk("t1_k0_clr", mmu_clear, 1);
      chk("t1_ready_after", mats_ready, 0);
      step("t1_k1", 0, 3'd0, '0, 1, 3'd1);
      chk("t1_k1_a0", a_row0, 2); chk("t1_k1_a1", a_row1, 3);
      chk("t1_k1_b0", b_col0, 7); chk("t1_k1_b1", b_col1, 6);
      step("t1_k2", 0, 3'd0, '0, 1, 3'd2);
      chk("t1_k2_a1", a_row1, 4); chk("t1_k2_b1", b_col1, 8); chk("t1_k2_a0", a_row0, 0);
      for (int k = 3; k <= 5; k++) begin
         step("t1_flush", 0, 3'd0, '0, 1, 3'(k));
         chk("t1_flush_valid", feed_valid, 0);
      end
      idle("t1_drain");
      idle("t1_idle");

      // Test 2: seven loads leave mats_ready low, the eighth raises it.
      for (int i = 0; i < 7; i++) step("t2_load", 1, 3'(i), DW'($urandom), 0, 3'd0);
      chk("t2_seven", mats_ready, 0);
      step("t2_load8", 1, 3'd7, DW'($urandom), 0, 3'd0);
      chk("t2_eight", mats_ready, 1);
      t2_a00 = m_mem[m_act][0];

`ifndef MMU_FEEDER_DOUBLE_BUF_EN
      // Test 3: load during feed cycle 2 is dropped and flagged until next feed start.
      step("t3_k0", 0, 3'd0, '0, 1, 3'd0);
      step("t3_k1", 0, 3'd0, '0, 1, 3'd1);
      step("t3_k2", 1, 3'd0, DW'(t2_a00 ^ 8'hA5), 1, 3'd2);
      chk("t3_err_set", load_err, 1);
      for (int k = 3; k <= 5; k++) step("t3_flush", 0, 3'd0, '0, 1, 3'(k));
      idle("t3_drain");
      idle("t3_idle");
      chk("t3_err_sticky", load_err, 1);
      step("t3_refeed", 0, 3'd0, '0, 1, 3'd0);
      chk("t3_storage_kept", a_row0, t2_a00);
      chk("t3_err_clr", load_err, 0);
      for (int k = 1; k <= 5; k++) step("t3_rest", 0, 3'd0, '0, 1, 3'(k));
      idle("t3_drain2");
`endif

      // Test 4: asynchronous reset during feed cycle 1.
      step("t4_k0", 0, 3'd0, '0, 1, 3'd0);
      feed_en = 1; feed_cycle = 3'd1;
      @(negedge clk); rst_n = 1'b0;
      #1;
      model_reset();
      chk("t4_rst_valid", feed_valid, 0);
      chk("t4_rst_a0", a_row0, 0);
      check_all("t4_rst");
      @(negedge clk); rst_n = 1'b1;
      step("t4_k0b", 0, 3'd0, '0, 1, 3'd0);
      chk("t4_zero_b0", b_col0, 0);
      chk("t4_valid", feed_valid, 1);
      for (int k = 1; k <= 5; k++) step("t4_rest", 0, 3'd0, '0, 1, 3'(k));
      idle("t4_drain");

      // Test 5: feed_en drops at cycle 1 -> drain, then idle.
      for (int i = 0; i < 8; i++) step("t5_load", 1, 3'(i), DW'(8'h20 + i), 0, 3'd0);
      step("t5_k0", 0, 3'd0, '0, 1, 3'd0);
      step("t5_drop", 0, 3'd0, '0, 0, 3'd1);
      chk("t5_drop_valid", feed_valid, 0);
      step("t5_drain", 0, 3'd0, '0, 1, 3'd0);
      chk("t5_drain_ignored", feed_valid, 0);
      step("t5_restart", 0, 3'd0, '0, 1, 3'd0);
      chk("t5_restart_valid", feed_valid, 1);
      for (int k = 1; k <= 5; k++) step("t5_rest", 0, 3'd0, '0, 1, 3'(k));
      idle("t5_drain2");

`ifdef MMU_FEEDER_DOUBLE_BUF_EN
      // Test 6: second set loaded into the shadow bank during a feed.
      for (int i = 0; i < 8; i++) step("t6_set1", 1, 3'(i), DW'(i + 1), 0, 3'd0);
      step("t6_pre", 1, 3'd0, DW'(9), 0, 3'd0);
      step("t6_pre", 1, 3'd1, DW'(10), 0, 3'd0);
      step("t6_k0", 1, 3'd2, DW'(11), 1, 3'd0);
      chk("t6_set1_a0", a_row0, 1); chk("t6_set1_b0", b_col0, 5);
      for (int k = 1; k <= 5; k++) step("t6_feed", 1, 3'(k + 2), DW'(k + 11), 1, 3'(k));
      chk("t6_no_swap_yet", mats_ready, 0);
      idle("t6_drain");
      chk("t6_swapped", mats_ready, 1);
      step("t6_k0b", 0, 3'd0, '0, 1, 3'd0);
      chk("t6_set2_a0", a_row0, 9); chk("t6_set2_b0", b_col0, 13);
      for (int k = 1; k <= 5; k++) step("t6_rest", 0, 3'd0, '0, 1, 3'(k));
      idle("t6_drain2");
`endif

      // Randomized traffic: load bursts, feeds (some aborted), and noise on feed inputs.
      for (int ep = 0; ep < 150; ep++) begin
         case ($urandom_range(0, 3))
            0, 1: for (int n = $urandom_range(1, 10); n > 0; n--)
                     step("rnd_load", 1'($urandom_range(0, 3) != 0), 3'($urandom), DW'($urandom), 0, 3'd0);
            2: begin
               int last;
               last = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 5;
               for (int k = 0; k <= last; k++)
                  step("rnd_feed", 1'($urandom_range(0, 4) == 0), 3'($urandom), DW'($urandom), 1, 3'(k));
               if (last < 5) step("rnd_abort", 0, 3'd0, '0, 0, 3'd0);
               idle("rnd_post");
            end
            default: for (int n = $urandom_range(1, 4); n > 0; n--)
                        step("rnd_noise", 1'($urandom), 3'($urandom), DW'($urandom), 1'($urandom), 3'($urandom));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
